// File: rtl/videout_pkg.sv
// Shared palette-word layout, line tracker states and the code-to-linear
// expansion used by every video output channel.
package videout_pkg;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned CODE_W    = 6;
  localparam int unsigned MAX_OUT_W = 10;

  localparam int unsigned R_NIB_HI  = 11;
  localparam int unsigned R_NIB_LO  = 8;
  localparam int unsigned G_NIB_HI  = 7;
  localparam int unsigned G_NIB_LO  = 4;
  localparam int unsigned B_NIB_HI  = 3;
  localparam int unsigned B_NIB_LO  = 0;

  localparam int unsigned R_LSB_BIT = 14;
  localparam int unsigned G_LSB_BIT = 13;
  localparam int unsigned B_LSB_BIT = 12;
  localparam int unsigned DARK_BIT  = 15;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  typedef enum logic {
    LINE_BLANK  = 1'b0,
    LINE_ACTIVE = 1'b1
  } line_state_e;

  // Left-align the code and refill the low bits with its own MSBs; the
  // result sits right-justified in out_w bits. For out_w = 5 this reduces
  // to plain truncation of the code LSB.
  function automatic logic [MAX_OUT_W-1:0] expand_code(
    input logic [CODE_W-1:0] code,
    input int unsigned       out_w
  );
    logic [2*CODE_W-1:0] rep;
    rep = {code, code};
    return MAX_OUT_W'(rep >> (2 * CODE_W - out_w));
  endfunction

endpackage

// File: rtl/videout_chan.sv
// One colour channel: palette field decode, width expansion, shadow and
// blanking. Purely combinational; the top level registers the result.
module videout_chan
  import videout_pkg::*;
#(
  parameter int unsigned OUT_W        = 8,
  parameter bit          SHADOW_HALVE = 1'b1,
  parameter chan_e       CHAN         = CH_R
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             shadow,
  input  logic             nbnkb,
  output logic [OUT_W-1:0] value_c
);

  logic [NIB_W-1:0]  nib;
  logic              ch_lsb;
  logic [CODE_W-1:0] code;
  logic [OUT_W-1:0]  expanded;
  logic [OUT_W-1:0]  shaded;

  // Field select for this channel
  always_comb begin
    nib    = pc[R_NIB_HI:R_NIB_LO];
    ch_lsb = pc[R_LSB_BIT];
    case (CHAN)
      CH_G: begin
        nib    = pc[G_NIB_HI:G_NIB_LO];
        ch_lsb = pc[G_LSB_BIT];
      end
      CH_B: begin
        nib    = pc[B_NIB_HI:B_NIB_LO];
        ch_lsb = pc[B_LSB_BIT];
      end
      default: ;
    endcase
  end

  // Dark bit set clears the code LSB, i.e. one step darker
  assign code     = {nib, ch_lsb, ~pc[DARK_BIT]};
  assign expanded = OUT_W'(expand_code(code, OUT_W));
  assign shaded   = (SHADOW_HALVE && shadow) ? (expanded >> 1) : expanded;
  assign value_c  = nbnkb ? shaded : '0;

endmodule

// File: rtl/videout_linear.sv
// Linear RGB video output stage: three channel decoders, a PIPE-deep output
// pipeline with aligned data-enable, and an active-run length tracker.
module videout_linear
  import videout_pkg::*;
#(
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned PIPE         = 2,
  parameter bit          SHADOW_HALVE = 1'b1,
  parameter int unsigned CNT_W        = 9
) (
  input  logic             CLK_6MB,
  input  logic             RESET,
  input  logic             nBNKB,
  input  logic             SHADOW,
  input  logic [PC_W-1:0]  PC,
  output logic [OUT_W-1:0] VIDEO_R,
  output logic [OUT_W-1:0] VIDEO_G,
  output logic [OUT_W-1:0] VIDEO_B,
  output logic             VIDEO_DE,
  output logic [CNT_W-1:0] LINE_LEN,
  output logic             LINE_STB
);

  localparam int unsigned      PIX_W   = 3 * OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_W-1:0] r_c;
  logic [OUT_W-1:0] g_c;
  logic [OUT_W-1:0] b_c;
  logic [PIX_W-1:0] pix_c;
  logic [PIX_W-1:0] pipe_q [PIPE];

  videout_chan #(.OUT_W(OUT_W), .SHADOW_HALVE(SHADOW_HALVE), .CHAN(CH_R)) u_chan_r (
    .pc      (PC),
    .shadow  (SHADOW),
    .nbnkb   (nBNKB),
    .value_c (r_c)
  );

  videout_chan #(.OUT_W(OUT_W), .SHADOW_HALVE(SHADOW_HALVE), .CHAN(CH_G)) u_chan_g (
    .pc      (PC),
    .shadow  (SHADOW),
    .nbnkb   (nBNKB),
    .value_c (g_c)
  );

  videout_chan #(.OUT_W(OUT_W), .SHADOW_HALVE(SHADOW_HALVE), .CHAN(CH_B)) u_chan_b (
    .pc      (PC),
    .shadow  (SHADOW),
    .nbnkb   (nBNKB),
    .value_c (b_c)
  );

  assign pix_c = {nBNKB, r_c, g_c, b_c};

  // First stage captures the decoded pixel straight from the inputs
  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      pipe_q[0] <= '0;
    end else begin
      pipe_q[0] <= pix_c;
    end
  end

  for (genvar s = 1; s < PIPE; s++) begin : g_pipe
    always_ff @(posedge CLK_6MB) begin
      if (RESET) begin
        pipe_q[s] <= '0;
      end else begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign {VIDEO_DE, VIDEO_R, VIDEO_G, VIDEO_B} = pipe_q[PIPE-1];

  // Run-length tracker; state doubles as the registered previous nBNKB
  line_state_e      state_q;
  line_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_d;
  logic             stb_d;

  always_ff @(posedge CLK_6MB) begin
    if (RESET) begin
      state_q  <= LINE_BLANK;
      cnt_q    <= '0;
      LINE_LEN <= '0;
      LINE_STB <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      LINE_LEN <= len_d;
      LINE_STB <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = LINE_LEN;
    stb_d   = 1'b0;
    case (state_q)
      LINE_BLANK: begin
        if (nBNKB) begin
          state_d = LINE_ACTIVE;
          cnt_d   = CNT_W'(1);
        end
      end
      LINE_ACTIVE: begin
        if (nBNKB) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Falling edge of the active window closes the line
          state_d = LINE_BLANK;
          len_d   = cnt_q;
          stb_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LINE_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_videout_linear.sv
// Scoreboard bench for videout_linear across several OUT_W/PIPE/SHADOW_HALVE/
// CNT_W builds driven by one shared stimulus stream.
module tb_videout_linear;

  localparam int NI = 7;
  localparam int PIPE_T  [NI] = '{1, 2, 3, 4, 2, 2, 3};
  localparam int OUTW_T  [NI] = '{8, 8, 8, 8, 8, 5, 10};
  localparam bit HALVE_T [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam int CNTW_T  [NI] = '{9, 9, 9, 9, 8, 9, 9};

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       de;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nb  = 1'b0;
  logic        sh  = 1'b0;
  logic [15:0] pc  = 16'h0000;

  int errors = 0;
  int checks = 0;

  exp_t sb [NI][$];
  int   m_cnt  [2];
  int   m_len  [2];
  bit   m_stb  [2];
  bit   m_prev [2];

  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4;
  logic [4:0] r5, g5, b5;
  logic [9:0] r6, g6, b6;
  logic       de0, de1, de2, de3, de4, de5, de6;
  logic       stb0, stb1, stb2, stb3, stb4, stb5, stb6;
  logic [8:0] len0, len1, len2, len3, len5, len6;
  logic [7:0] len4;

  always #5 clk = ~clk;

  videout_linear #(.OUT_W(8), .PIPE(1), .SHADOW_HALVE(1'b1), .CNT_W(9)) u0 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r0), .VIDEO_G(g0), .VIDEO_B(b0), .VIDEO_DE(de0), .LINE_LEN(len0), .LINE_STB(stb0));
  videout_linear #(.OUT_W(8), .PIPE(2), .SHADOW_HALVE(1'b1), .CNT_W(9)) u1 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r1), .VIDEO_G(g1), .VIDEO_B(b1), .VIDEO_DE(de1), .LINE_LEN(len1), .LINE_STB(stb1));
  videout_linear #(.OUT_W(8), .PIPE(3), .SHADOW_HALVE(1'b1), .CNT_W(9)) u2 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r2), .VIDEO_G(g2), .VIDEO_B(b2), .VIDEO_DE(de2), .LINE_LEN(len2), .LINE_STB(stb2));
  videout_linear #(.OUT_W(8), .PIPE(4), .SHADOW_HALVE(1'b1), .CNT_W(9)) u3 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r3), .VIDEO_G(g3), .VIDEO_B(b3), .VIDEO_DE(de3), .LINE_LEN(len3), .LINE_STB(stb3));
  videout_linear #(.OUT_W(8), .PIPE(2), .SHADOW_HALVE(1'b0), .CNT_W(8)) u4 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r4), .VIDEO_G(g4), .VIDEO_B(b4), .VIDEO_DE(de4), .LINE_LEN(len4), .LINE_STB(stb4));
  videout_linear #(.OUT_W(5), .PIPE(2), .SHADOW_HALVE(1'b1), .CNT_W(9)) u5 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r5), .VIDEO_G(g5), .VIDEO_B(b5), .VIDEO_DE(de5), .LINE_LEN(len5), .LINE_STB(stb5));
  videout_linear #(.OUT_W(10), .PIPE(3), .SHADOW_HALVE(1'b1), .CNT_W(9)) u6 (
    .CLK_6MB(clk), .RESET(rst), .nBNKB(nb), .SHADOW(sh), .PC(pc),
    .VIDEO_R(r6), .VIDEO_G(g6), .VIDEO_B(b6), .VIDEO_DE(de6), .LINE_LEN(len6), .LINE_STB(stb6));

  // Reference channel value: build the output bit by bit from the 6-bit code
  function automatic logic [9:0] model_chan(input logic [3:0] nib, input logic lsb,
                                            input logic dark, input logic shd,
                                            input logic act, input int w, input bit halve);
    logic [5:0] code;
    logic [9:0] v;
    code = {nib, lsb, ~dark};
    v = '0;
    for (int k = 0; k < w; k++) v[w-1-k] = code[5-(k%6)];
    if (halve && shd) v = v >> 1;
    if (!act) v = '0;
    return v;
  endfunction

  function automatic exp_t get_pix(input int i);
    exp_t o;
    case (i)
      0: o = '{r: 10'(r0), g: 10'(g0), b: 10'(b0), de: de0};
      1: o = '{r: 10'(r1), g: 10'(g1), b: 10'(b1), de: de1};
      2: o = '{r: 10'(r2), g: 10'(g2), b: 10'(b2), de: de2};
      3: o = '{r: 10'(r3), g: 10'(g3), b: 10'(b3), de: de3};
      4: o = '{r: 10'(r4), g: 10'(g4), b: 10'(b4), de: de4};
      5: o = '{r: 10'(r5), g: 10'(g5), b: 10'(b5), de: de5};
      default: o = '{r: r6, g: g6, b: b6, de: de6};
    endcase
    return o;
  endfunction

  function automatic logic [10:0] get_line(input int i);
    logic [10:0] o;
    case (i)
      0: o = {stb0, 10'(len0)};
      1: o = {stb1, 10'(len1)};
      2: o = {stb2, 10'(len2)};
      3: o = {stb3, 10'(len3)};
      4: o = {stb4, 10'(len4)};
      5: o = {stb5, 10'(len5)};
      default: o = {stb6, 10'(len6)};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  // Drive one cycle: push expectations, clock, then pop and compare
  task automatic cyc(input logic r, input logic n, input logic s, input logic [15:0] p);
    exp_t e;
    exp_t o;
    logic [10:0] lo;
    logic [10:0] lx;
    int c;
    rst = r; nb = n; sh = s; pc = p;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        sb[i].delete();
        for (int k = 0; k < PIPE_T[i]; k++) sb[i].push_back('0);
      end else begin
        e.r  = model_chan(p[11:8], p[14], p[15], s, n, OUTW_T[i], HALVE_T[i]);
        e.g  = model_chan(p[7:4],  p[13], p[15], s, n, OUTW_T[i], HALVE_T[i]);
        e.b  = model_chan(p[3:0],  p[12], p[15], s, n, OUTW_T[i], HALVE_T[i]);
        e.de = n;
        sb[i].push_back(e);
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (r) begin
        m_cnt[j] = 0; m_len[j] = 0; m_stb[j] = 1'b0; m_prev[j] = 1'b0;
      end else begin
        m_stb[j] = m_prev[j] && !n;
        if (m_stb[j]) m_len[j] = m_cnt[j];
        if (n) m_cnt[j] = (m_cnt[j] == ((j == 0) ? 511 : 255)) ? m_cnt[j] : m_cnt[j] + 1;
        else   m_cnt[j] = 0;
        m_prev[j] = n;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (sb[i].size() >= PIPE_T[i]) begin
        e = sb[i].pop_front();
        o = get_pix(i);
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL pix%0d observed=%h expected=%h", i, o, e);
        end
      end
      c  = (CNTW_T[i] == 8) ? 1 : 0;
      lo = get_line(i);
      lx = {m_stb[c], 10'(m_len[c])};
      checks++;
      assert (lo === lx) else begin
        errors++;
        $error("FAIL line%0d observed=%h expected=%h", i, lo, lx);
      end
    end
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("reset_r", 16'(r1), 16'h0000);
    chk("reset_len", 16'(len1), 16'h0000);

    repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h7FFF);
    chk("white_r", 16'(r1), 16'h00FF);
    chk("white_de", 16'(de1), 16'h0001);

    repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'hFFFF);
    chk("dark_g", 16'(g1), 16'h00FB);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h8000);
    chk("dark_zero_b", 16'(b1), 16'h0000);

    repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'h7FFF);
    chk("shadow_half", 16'(r1), 16'h007F);
    chk("shadow_off", 16'(r4), 16'h00FF);
    chk("shadow_w5", 16'(r5), 16'h000F);

    for (int t = 0; t < 24; t++) cyc(1'b0, ((t / 3) % 2) != 0, 1'b0, 16'h7F00);

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int t = 0; t < 320; t++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("len320", 16'(len1), 16'd320);
    chk("stb320", 16'(stb1), 16'h0001);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("stb_single", 16'(stb1), 16'h0000);

    for (int t = 0; t < 300; t++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("len_sat", 16'(len4), 16'd255);
    chk("len300", 16'(len1), 16'd300);

    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 16'h1234);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("len1", 16'(len1), 16'd1);

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int t = 0; t < 100; t++) cyc(1'b0, 1'b1, 1'b0, 16'h7FFF);
    cyc(1'b1, 1'b1, 1'b0, 16'h7FFF);
    chk("rst_mid_r", 16'(r3), 16'h0000);
    for (int t = 0; t < 50; t++) cyc(1'b0, 1'b1, 1'b0, 16'h7FFF);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("len_after_rst", 16'(len1), 16'd50);

    for (int t = 0; t < 200; t++)
      cyc(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/videout_linear.md
Name: videout_linear

Overview:
- Parametrised successor to the fixed 7-bit-per-channel video output latch.
- Decodes the 16-bit palette word (4-bit colour nibbles, per-channel LSBs in PC[14:12], shared dark bit PC[15]) into linear OUT_W-bit RGB.
- Also handles shadow attenuation, blanking and a configurable-depth output pipeline with an aligned data-enable.
- Measures the active-pixel run length of each line for the sync/timing checker. Sits between the palette RAM read path and the video DAC/encoder.

Parameters:
- OUT_W, 8, output bits per channel; legal 5..10.
- PIPE, 2, total register stages from input to outputs; legal 1..4.
- SHADOW_HALVE, 1, 1 = shadow halves intensity; 0 = shadow ignored.
- CNT_W, 9, width of active-run counter; saturates at all-ones.

Ports:
- CLK_6MB  in  1  pixel clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- nBNKB  in  1  active-low blanking; 1 = active pixel.
- SHADOW  in  1  shadow flag for the current pixel.
- PC  in  16  palette colour word.
- VIDEO_R  out  OUT_W  red, linear.
- VIDEO_G  out  OUT_W  green, linear.
- VIDEO_B  out  OUT_W  blue, linear.
- VIDEO_DE  out  1  data enable aligned with VIDEO_R/G/B.
- LINE_LEN  out  CNT_W  active pixels counted in the last completed line.
- LINE_STB  out  1  one-cycle pulse when LINE_LEN updates.

Behaviour:
- Reset: when RESET=1 at a clock edge, all pipeline stages, VIDEO_R/G/B, VIDEO_DE, LINE_LEN, LINE_STB and the run counter go to 0 on that edge.
  - Reset mid-line discards the partial count. No LINE_STB is produced for that line.
  - Pipeline refills normally after reset; outputs stay 0 for PIPE cycles.
- Channel decode, stage 1:
  - 6-bit code = {nibble, chLSB, ~PC[15]}.
  - Nibbles: R = PC[11:8], G = PC[7:4], B = PC[3:0].
  - chLSB: R = PC[14], G = PC[13], B = PC[12].
  - Dark bit set lowers the code by 1 (code LSB = 0).
- Width expansion:
  - OUT_W ≥ 6: code is left-aligned and its MSBs are replicated into the low bits, so 63 maps to all-ones and 0 maps to 0.
  - OUT_W = 5: code[5:1] is output (truncation, no rounding).
- Shadow: with SHADOW_HALVE=1 and SHADOW=1, the expanded value is logically shifted right by 1 (MSB = 0).
- Blanking: nBNKB=0 forces all channels to 0 regardless of PC/SHADOW.
- Latency:
  - Inputs sampled at edge N appear on VIDEO_* after edge N+PIPE-1.
  - VIDEO_DE = nBNKB delayed identically to the colour data.
  - No combinational input-to-output paths.
- Run counter:
  - Increments on each cycle with nBNKB=1, saturating at 2^CNT_W-1.
  - On a 1→0 transition of nBNKB (registered previous value 1, current 0):
    - LINE_LEN is loaded with the count including the last active pixel;
    - LINE_STB=1 for exactly that cycle;
    - the counter clears.
  - A 0→1 transition starts counting at 1 on that cycle.
  - A line of length 1 is reported as 1.
  - LINE_LEN holds its value between strobes.
  - The counter is not delayed by PIPE; LINE_STB is valid one cycle after the sampled falling edge.

Decomposition:
- Package videout_pkg holds:
  - palette field bit-position constants (nibble ranges, LSB bits 14..12, dark bit 15);
  - the 6-bit code width constant;
  - the function that expands a 6-bit code to OUT_W bits.
- One sub-module, videout_chan (decode + expand + shadow + blank for one channel), instantiated three times.
- Pipeline delay and run counter live in the top level.

Test Plan:
- Full white, no dark/shadow: PC=16'h7FFF, SHADOW=0, nBNKB=1, OUT_W=8, PIPE=2 → VIDEO_R/G/B=8'hFF and VIDEO_DE=1 two edges after sampling (after edge N+1).
- Dark bit: PC=16'hFFFF → code 62 → 8'hFB each; PC=16'h8000 → 0.
- Shadow halving: PC=16'h7FFF, SHADOW=1 → 8'h7F; with SHADOW_HALVE=0 → 8'hFF.
- Blanking and latency sweep: toggle nBNKB every 3 cycles with PC=16'h7F00 for PIPE=1..4 → R=FF/0 and DE track nBNKB exactly PIPE-1 edges late; G=B=0 throughout.
- Run counter: 320 active cycles, then nBNKB=0 → LINE_LEN=320 with a single LINE_STB. With CNT_W=8, 300 active cycles → LINE_LEN=255 (saturated). A single-cycle active pulse → LINE_LEN=1.
- Reset mid-line: assert RESET for 1 cycle after 100 active pixels, then 50 more active pixels and blank → LINE_LEN=50; outputs 0 for PIPE cycles after reset.
